// File: rtl/tl_phase_scheduler.sv
// tl_phase_scheduler
// Request scheduler in front of the traffic-light phase FSM. Up to NREQ
// request pulses are latched into a pending set, and a round-robin arbiter
// picks one of them. The winner is offered to the light FSM as a single grant
// over a valid/ack handshake. Each accepted grant starts a holdoff of GAP_S
// one-second ticks, so phases cannot be cycled faster than the safe rate.
//
// Optional feature macro: TL_SCHED_PRIO_EN
//   When it is defined, requester 0 is an emergency source. It wins
//   arbitration whenever it is pending, it aborts a running holdoff, and a
//   grant to it leaves the round-robin pointer unchanged.
//   When it is undefined (the default), the arbiter is pure round-robin and a
//   holdoff always runs to completion.
module tl_phase_scheduler #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int GAP_S = 10,
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_1s,
  input  logic             enable,
  input  logic [NREQ-1:0]  req_pulse,
  output logic             grant_valid,
  output logic [IDW-1:0]   grant_id,
  input  logic             grant_ack,
  output logic [NREQ-1:0]  pending,
  output logic             busy,
  output logic [CNT_W-1:0] holdoff_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARB     = 2'd1,
    S_ISSUE   = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [NREQ-1:0]  pending_q, pending_d;
  logic             grant_valid_q, grant_valid_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] holdoff_q, holdoff_d;
  logic             busy_q, busy_d;
  logic [IDW-1:0]   winner;

  // Round-robin search: the first set bit at or above ptr, wrapping at NREQ-1.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                             input logic [IDW-1:0]  ptr);
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    logic           found;
    int             pos;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      idx = IDW'(pos);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  // Successor index modulo NREQ, so it also works when NREQ is not a power of 2.
  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    logic [IDW-1:0] nxt;
    if (int'(id) >= NREQ - 1) nxt = '0;
    else                      nxt = id + IDW'(1);
    return nxt;
  endfunction

  // Arbitration winner. The priority build lets requester 0 pre-empt the ring.
  always_comb begin
    winner = rr_pick(pending_q, rr_ptr_q);
`ifdef TL_SCHED_PRIO_EN
    if (pending_q[0]) winner = '0;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and next register values. Defaults hold every register.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    holdoff_d     = holdoff_q;

    if (!enable) begin
      // Night/setup mode flushes the scheduler. The round-robin position is kept.
      state_d       = S_IDLE;
      pending_d     = '0;
      grant_valid_d = 1'b0;
      holdoff_d     = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (|pending_q) state_d = S_ARB;
        end

        S_ARB: begin
          if (|pending_q) begin
            grant_id_d    = winner;
            grant_valid_d = 1'b1;
            state_d       = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_ISSUE: begin
          if (grant_ack) begin
            grant_valid_d         = 1'b0;
            pending_d[grant_id_q] = 1'b0;
`ifdef TL_SCHED_PRIO_EN
            if (grant_id_q != '0) rr_ptr_d = next_id(grant_id_q);
`else
            rr_ptr_d = next_id(grant_id_q);
`endif
            if (GAP_S == 0) begin
              holdoff_d = '0;
              state_d   = S_IDLE;
            end else begin
              holdoff_d = CNT_W'(GAP_S);
              state_d   = S_HOLDOFF;
            end
          end
        end

        S_HOLDOFF: begin
`ifdef TL_SCHED_PRIO_EN
          if (pending_q[0]) begin
            // An emergency request cuts the holdoff short.
            holdoff_d = '0;
            state_d   = S_ARB;
          end else if (tick_1s) begin
            if (holdoff_q <= CNT_W'(1)) begin
              holdoff_d = '0;
              state_d   = S_IDLE;
            end else begin
              holdoff_d = holdoff_q - CNT_W'(1);
            end
          end
`else
          if (tick_1s) begin
            // Saturate at zero so the counter can never wrap.
            if (holdoff_q <= CNT_W'(1)) begin
              holdoff_d = '0;
              state_d   = S_IDLE;
            end else begin
              holdoff_d = holdoff_q - CNT_W'(1);
            end
          end
`endif
        end

        default: begin
          state_d       = S_IDLE;
          grant_valid_d = 1'b0;
          holdoff_d     = '0;
        end
      endcase

      // New pulses are applied after any grant clear, so a pulse on the ack
      // edge keeps its bit set.
      pending_d = pending_d | req_pulse;
    end
  end

  assign busy_d = (state_d != S_IDLE);

  // Registered datapath and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q     <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
      holdoff_q     <= '0;
      busy_q        <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      holdoff_q     <= holdoff_d;
      busy_q        <= busy_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign pending     = pending_q;
  assign busy        = busy_q;
  assign holdoff_cnt = holdoff_q;

endmodule

// File: tb/tb_tl_phase_scheduler.sv
// Bench for tl_phase_scheduler. It runs a directed scenario table and then
// randomized stimulus. A reference model predicts the outputs after every
// clock edge and queues them. A separate monitor pops each entry and compares
// it with what the DUT presents.
module tb_tl_phase_scheduler;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int GAP_S = 3;
  localparam int CNT_W = 11;
`ifdef TL_SCHED_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             tick_1s;
  logic             enable;
  logic [NREQ-1:0]  req_pulse;
  logic             grant_valid;
  logic [IDW-1:0]   grant_id;
  logic             grant_ack;
  logic [NREQ-1:0]  pending;
  logic             busy;
  logic [CNT_W-1:0] holdoff_cnt;

  always #5 clk = ~clk;

  tl_phase_scheduler #(.NREQ(NREQ), .IDW(IDW), .GAP_S(GAP_S), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1s(tick_1s), .enable(enable),
    .req_pulse(req_pulse), .grant_valid(grant_valid), .grant_id(grant_id),
    .grant_ack(grant_ack), .pending(pending), .busy(busy),
    .holdoff_cnt(holdoff_cnt)
  );

  typedef struct {
    int gv;
    int gid;
    int pend;
    int busy;
    int hold;
  } snap_t;

  snap_t exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model, kept as the scheduler's observable situation:
  //   0 = waiting, 1 = choosing a winner, 2 = offering a grant, 3 = cooling down.
  int          m_phase = 0;
  bit [NREQ-1:0] m_pend = '0;
  int          m_gv = 0, m_gid = 0, m_rr = 0, m_hold = 0;

  function automatic int pick_winner();
    if (PRIO && m_pend[0]) return 0;
    for (int k = 0; k < NREQ; k++) begin
      if (m_pend[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic model_edge(input bit [NREQ-1:0] r, input bit a, input bit t, input bit e);
    bit [NREQ-1:0] np;
    if (!e) begin
      m_phase = 0; m_pend = '0; m_gv = 0; m_hold = 0;
      return;
    end
    np = m_pend;
    case (m_phase)
      0: if (m_pend != 0) m_phase = 1;
      1: begin
        m_gid = pick_winner();
        m_gv = 1;
        m_phase = 2;
      end
      2: if (a) begin
        m_gv = 0;
        np[m_gid] = 1'b0;
        if (!(PRIO && m_gid == 0)) m_rr = (m_gid + 1) % NREQ;
        m_hold = GAP_S;
        m_phase = (GAP_S == 0) ? 0 : 3;
      end
      default: begin
        if (PRIO && m_pend[0]) begin
          m_hold = 0;
          m_phase = 1;
        end else if (t) begin
          m_hold = m_hold - 1;
          if (m_hold <= 0) begin
            m_hold = 0;
            m_phase = 0;
          end
        end
      end
    endcase
    m_pend = np | r;
  endtask

  // Drive one cycle of inputs, advance the model, and queue the expected outputs.
  task automatic step(input bit [NREQ-1:0] r, input bit a, input bit t, input bit e);
    snap_t s;
    @(negedge clk);
    req_pulse = r; grant_ack = a; tick_1s = t; enable = e;
    model_edge(r, a, t, e);
    @(posedge clk);
    s.gv = m_gv; s.gid = m_gid; s.pend = int'(m_pend);
    s.busy = (m_phase != 0) ? 1 : 0; s.hold = m_hold;
    exp_q.push_back(s);
  endtask

  // Monitor: compare every queued prediction against the DUT away from the edge.
  initial begin
    snap_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant_valid", int'(grant_valid), e.gv);
        chk("grant_id",    int'(grant_id),    e.gid);
        chk("pending",     int'(pending),     e.pend);
        chk("busy",        int'(busy),        e.busy);
        chk("holdoff_cnt", int'(holdoff_cnt), e.hold);
      end
    end
  end

  initial begin
    bit [NREQ-1:0] r;
    bit a, t, e;
    rst_n = 1'b0; tick_1s = 1'b0; enable = 1'b0; req_pulse = '0; grant_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst grant_valid", int'(grant_valid), 0);
    chk("rst grant_id",    int'(grant_id),    0);
    chk("rst pending",     int'(pending),     0);
    chk("rst busy",        int'(busy),        0);
    chk("rst holdoff_cnt", int'(holdoff_cnt), 0);
    rst_n = 1'b1;

    // Single request, ack a few cycles later, then wait out the holdoff.
    repeat (3) step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0, 1'b1);
    repeat (4) step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0, 1'b1);
    repeat (3) step(4'b0000, 1'b0, 1'b0, 1'b1);
    repeat (3) begin
      step(4'b0000, 1'b0, 1'b1, 1'b1);
      step(4'b0000, 1'b0, 1'b0, 1'b1);
    end
    repeat (4) step(4'b0000, 1'b1, 1'b0, 1'b1);

    // All four requesting: round-robin order, each grant acked at once.
    step(4'b1111, 1'b0, 1'b0, 1'b1);
    repeat (30) step(4'b0000, 1'b1, 1'b1, 1'b1);
    step(4'b1001, 1'b0, 1'b0, 1'b1);
    repeat (16) step(4'b0000, 1'b1, 1'b1, 1'b1);

    // Same id re-requested on its ack edge stays pending.
    step(4'b0010, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0010, 1'b1, 1'b0, 1'b1);
    repeat (12) step(4'b0000, 1'b1, 1'b1, 1'b1);

    // Emergency request during a holdoff (aborts only in the priority build).
    step(4'b0100, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b0, 1'b1);
    repeat (4) step(4'b0000, 1'b0, 1'b0, 1'b1);
    repeat (10) step(4'b0000, 1'b1, 1'b1, 1'b1);

    // Flush while a grant is offered, then pulses while disabled are dropped.
    step(4'b0110, 1'b0, 1'b0, 1'b1);
    repeat (3) step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b0110, 1'b1, 1'b1, 1'b0);
    repeat (3) step(4'b0000, 1'b0, 1'b0, 1'b1);

    // Randomized traffic: sparse requests, random acks, ticks and flushes.
    for (int c = 0; c < 4000; c++) begin
      r = '0;
      for (int b = 0; b < NREQ; b++) if ($urandom_range(0, 11) == 0) r[b] = 1'b1;
      a = ($urandom_range(0, 2) == 0);
      t = ($urandom_range(0, 5) == 0);
      e = ($urandom_range(0, 99) != 0);
      step(r, a, t, e);
    end

    @(negedge clk);
    #2;
    chk("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
